// File: rtl/host_io_sequencer_if.sv
// Host load stream, shared-memory port and unload stream of host_io_sequencer.
// The master modport is the sequencer side; slave is the host/memory side.
interface host_io_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              load_start;
    logic              host_wr_valid;
    logic [DATA_W-1:0] host_data_in;
    logic              load_done;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_start;
    logic              out_done;

    modport master (
        input  load_start, host_wr_valid, host_data_in, load_done, mem_rdata, out_ready,
        output mem_addr, mem_wdata, mem_wr_en, out_data, out_valid, out_start, out_done
    );

    modport slave (
        output load_start, host_wr_valid, host_data_in, load_done, mem_rdata, out_ready,
        input  mem_addr, mem_wdata, mem_wr_en, out_data, out_valid, out_start, out_done
    );
endinterface

// File: rtl/host_io_sequencer.sv
// Load/run/unload sequencer: host words -> shared memory, start and join N cores, stream a result window back.
// Optional RUN-phase watchdog is compiled in with `define RUN_TIMEOUT_EN.
module host_io_sequencer #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int NUM_CORES      = 4,
    parameter int OUT_BASE       = 0,
    parameter int OUT_WORDS      = 1025,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    host_io_sequencer_if.master  bus,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 core_start,
    output logic [1:0]           state,
    output logic [ADDR_W:0]      load_count,
    output logic                 overflow_err,
    output logic                 timeout_err
);
    typedef enum logic [1:0] {
        ST_LOAD   = 2'b00,
        ST_RUN    = 2'b01,
        ST_UNLOAD = 2'b10,
        ST_IDLE   = 2'b11
    } state_t;

    localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] OUT_BASE_L = (ADDR_W+1)'(OUT_BASE);
    localparam logic [ADDR_W:0] LAST_IDX   = (ADDR_W+1)'(OUT_WORDS - 1);

    if (OUT_WORDS < 1 || TIMEOUT_CYCLES < 1 || OUT_BASE + OUT_WORDS > 2**ADDR_W) begin : g_bad_params
        $error("host_io_sequencer: unload window or timeout out of range");
    end

    state_t               state_q;
    logic [NUM_CORES-1:0] done_latch;
    logic [ADDR_W:0]      rd_addr;
    logic [ADDR_W:0]      out_cnt;
    logic                 rd_first;
    logic                 rd_wait;
    logic                 load_full;
    logic                 wr_fire;
    logic                 all_done;
    logic                 handshake;
    logic                 last_word;
    logic                 rd_issue;
    logic                 run_expired;
    logic                 go_unload;

    assign state     = state_q;
    // load_count doubles as the write pointer; its top bit marks a full address space.
    assign load_full = load_count[ADDR_W];
    assign wr_fire   = (state_q == ST_LOAD) && bus.host_wr_valid && !load_full && !rst;
    assign all_done  = &(done_latch | core_done);
    assign handshake = (state_q == ST_UNLOAD) && bus.out_valid && bus.out_ready;
    assign last_word = (out_cnt == LAST_IDX);
    assign rd_issue  = (state_q == ST_UNLOAD) && (rd_first || (handshake && !last_word));
    assign go_unload = (state_q == ST_RUN) && (all_done || run_expired);

    assign bus.mem_wr_en = wr_fire;
    assign bus.mem_wdata = bus.host_data_in;

    always_comb begin
        // NOTE: default first so every path assigns mem_addr and no latch is inferred.
        bus.mem_addr = '0;
        case (state_q)
            ST_LOAD:   bus.mem_addr = load_count[ADDR_W-1:0];
            ST_UNLOAD: bus.mem_addr = rd_addr[ADDR_W-1:0];
            default:   bus.mem_addr = '0;
        endcase
    end

`ifdef RUN_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] run_cnt;

    assign run_expired = (state_q == ST_RUN) && !all_done && (run_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst || state_q != ST_RUN) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (state_q == ST_IDLE && bus.load_start) begin
            timeout_err <= 1'b0;
        end else if (run_expired) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign run_expired = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            load_count    <= '0;
            overflow_err  <= 1'b0;
            core_start    <= 1'b0;
            done_latch    <= '0;
            rd_addr       <= '0;
            out_cnt       <= '0;
            rd_first      <= 1'b0;
            rd_wait       <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_start <= 1'b0;
            bus.out_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            core_start   <= 1'b0;
            bus.out_done <= 1'b0;
            rd_wait      <= rd_issue;

            // Memory answers one cycle after the address; capture it then.
            if (rd_issue) begin
                rd_addr  <= rd_addr + ONE;
                rd_first <= 1'b0;
            end
            if (rd_wait) begin
                bus.out_data  <= bus.mem_rdata;
                bus.out_valid <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        state_q      <= ST_LOAD;
                        load_count   <= '0;
                        overflow_err <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (wr_fire) begin
                        load_count <= load_count + ONE;
                    end else if (bus.host_wr_valid) begin
                        overflow_err <= 1'b1;
                    end
                    if (bus.load_done) begin
                        state_q    <= ST_RUN;
                        core_start <= 1'b1;
                    end
                end
                ST_RUN: begin
                    done_latch <= done_latch | core_done;
                    if (go_unload) begin
                        state_q       <= ST_UNLOAD;
                        done_latch    <= '0;
                        rd_addr       <= OUT_BASE_L;
                        rd_first      <= 1'b1;
                        out_cnt       <= '0;
                        bus.out_start <= 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (handshake) begin
                        bus.out_valid <= 1'b0;
                        out_cnt       <= out_cnt + ONE;
                        if (last_word) begin
                            state_q       <= ST_IDLE;
                            bus.out_start <= 1'b0;
                            bus.out_done  <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_host_io_sequencer.sv
// Directed bench for host_io_sequencer (ADDR_W=3, 4-word unload window, 20-cycle watchdog when enabled).
`timescale 1ns/1ps
module tb_host_io_sequencer;
    localparam int DATA_W         = 16;
    localparam int ADDR_W         = 3;
    localparam int NUM_CORES      = 4;
    localparam int OUT_BASE       = 0;
    localparam int OUT_WORDS      = 4;
    localparam int TIMEOUT_CYCLES = 20;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_CORES-1:0] core_done = '0;
    logic                 core_start;
    logic [1:0]           state;
    logic [ADDR_W:0]      load_count;
    logic                 overflow_err;
    logic                 timeout_err;

    host_io_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    host_io_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CORES(NUM_CORES),
        .OUT_BASE(OUT_BASE), .OUT_WORDS(OUT_WORDS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .core_done(core_done), .core_start(core_start),
        .state(state), .load_count(load_count), .overflow_err(overflow_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    wr_t               wr_log[$];

    // External memory: synchronous write, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_log.push_back('{addr: bus.mem_addr, data: bus.mem_wdata});
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drains one unload window; with toggle set, ready alternates on every valid cycle.
    task automatic unload(input logic [DATA_W-1:0] base, input bit toggle);
        int                got = 0;
        int                cyc = 0;
        bit                held = 1'b0;
        bit                rdy_phase = 1'b0;
        logic [DATA_W-1:0] prev = '0;
        check("unload_out_start", bus.out_start, 1);
        while (got < OUT_WORDS && cyc < 200) begin
            bus.out_ready = toggle ? rdy_phase : 1'b1;
            if (bus.out_valid) rdy_phase = ~rdy_phase;
            #1;
            if (bus.out_valid) begin
                if (held) check("unload_hold", bus.out_data, prev);
                if (bus.out_ready) begin
                    check($sformatf("unload_word%0d", got), bus.out_data, DATA_W'(base + got));
                    got++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    prev = bus.out_data;
                end
            end
            step();
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("unload_count", got, OUT_WORDS);
        check("unload_done_pulse", bus.out_done, 1);
        check("unload_start_low", bus.out_start, 0);
        check("unload_to_idle", state, 2'b11);
        check("unload_valid_low", bus.out_valid, 0);
        step();
        check("unload_done_one_cycle", bus.out_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cs_count;
        int n;
        logic [NUM_CORES-1:0] stagger [5];
        stagger = '{4'b0001, 4'b0010, 4'b0100, 4'b0000, 4'b1000};
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
        bus.load_start    = 1'b0;
        bus.host_wr_valid = 1'b0;
        bus.host_data_in  = '0;
        bus.load_done     = 1'b0;
        bus.out_ready     = 1'b0;

        repeat (3) step();
        rst = 1'b0;
        check("rst_state", state, 2'b11);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_start", bus.out_start, 0);
        check("rst_out_done", bus.out_done, 0);
        check("rst_core_start", core_start, 0);
        check("rst_load_count", load_count, 0);
        check("rst_overflow", overflow_err, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wr_en", bus.mem_wr_en, 0);

        // Gapped load of 8 words, load_done on its own cycle.
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        check("a_state_load", state, 2'b00);
        for (int i = 0; i < 8; i++) begin
            bus.host_wr_valid = 1'b1;
            bus.host_data_in  = DATA_W'(16'h1000 + i);
            step();
            bus.host_wr_valid = 1'b0;
            bus.host_data_in  = 16'hDEAD;
            step();
        end
        bus.load_done = 1'b1;
        step();
        bus.load_done = 1'b0;
        check("a_writes", wr_log.size(), 8);
        for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
            check($sformatf("a_addr%0d", i), wr_log[i].addr, i);
            check($sformatf("a_data%0d", i), wr_log[i].data, 16'h1000 + i);
        end
        check("a_load_count", load_count, 8);
        check("a_no_overflow", overflow_err, 0);
        check("a_state_run", state, 2'b01);
        check("a_core_start", core_start, 1);
        check("a_no_wr_in_run", bus.mem_wr_en, 0);
        core_done = 4'hF;
        step();
        core_done = '0;
        check("a_state_unload", state, 2'b10);
        unload(16'h1000, 1'b0);

        // load_done coincident with the 5th word; staggered completion; toggling ready.
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        wr_log.delete();
        for (int i = 0; i < 5; i++) begin
            bus.host_wr_valid = 1'b1;
            bus.host_data_in  = DATA_W'(16'h00A0 + i);
            bus.load_done     = (i == 4);
            step();
        end
        bus.host_wr_valid = 1'b0;
        bus.load_done     = 1'b0;
        check("b_writes", wr_log.size(), 5);
        if (wr_log.size() == 5) check("b_last_write", wr_log[4], {3'd4, 16'h00A4});
        check("b_load_count", load_count, 5);
        check("b_state_run", state, 2'b01);
        cs_count = int'(core_start);
        for (int k = 0; k < 5; k++) begin
            core_done = stagger[k];
            step();
            cs_count += int'(core_start);
            check($sformatf("b_stagger%0d_state", k), state, (k < 4) ? 2'b01 : 2'b10);
        end
        core_done = '0;
        check("b_core_start_once", cs_count, 1);
        unload(16'h00A0, 1'b1);

        // Overflow: 10 words into an 8-word space.
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        wr_log.delete();
        for (int i = 0; i < 10; i++) begin
            bus.host_wr_valid = 1'b1;
            bus.host_data_in  = DATA_W'(16'h2000 + i);
            step();
        end
        bus.host_wr_valid = 1'b0;
        bus.load_done     = 1'b1;
        step();
        bus.load_done = 1'b0;
        check("c_writes", wr_log.size(), 8);
        if (wr_log.size() == 8) check("c_last_write", wr_log[7], {3'd7, 16'h2007});
        check("c_overflow", overflow_err, 1);
        check("c_load_count", load_count, 8);
        core_done = 4'hF;
        step();
        core_done = '0;
        unload(16'h2000, 1'b0);
        check("c_overflow_sticky", overflow_err, 1);
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        check("c_overflow_cleared", overflow_err, 0);
        check("c_load_count_cleared", load_count, 0);

        // Reset in the middle of an unload with out_valid high.
        wr_log.delete();
        bus.load_done = 1'b1;
        step();
        bus.load_done = 1'b0;
        core_done = 4'hF;
        step();
        core_done = '0;
        n = 0;
        while (!bus.out_valid && n < 10) begin
            step();
            n++;
        end
        check("d_valid_before_rst", bus.out_valid, 1);
        rst = 1'b1;
        step();
        check("d_rst_state", state, 2'b11);
        check("d_rst_out_valid", bus.out_valid, 0);
        check("d_rst_out_start", bus.out_start, 0);
        check("d_no_writes", wr_log.size(), 0);
        rst = 1'b0;
        step();

        // RUN with no core ever finishing.
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        bus.load_done  = 1'b1;
        step();
        bus.load_done = 1'b0;
        check("e_state_run", state, 2'b01);
`ifdef RUN_TIMEOUT_EN
        n = 0;
        while (state == 2'b01 && n < 100) begin
            step();
            n++;
        end
        check("e_run_cycles", n, TIMEOUT_CYCLES);
        check("e_timeout_err", timeout_err, 1);
        check("e_state_unload", state, 2'b10);
        unload(16'h2000, 1'b0);
        check("e_timeout_sticky", timeout_err, 1);
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        check("e_timeout_cleared", timeout_err, 0);
`else
        repeat (30) step();
        check("e_still_run", state, 2'b01);
        check("e_no_timeout", timeout_err, 0);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
